// File: rtl/anim_frame_sequencer.sv
// Frame engine for the 7-segment animation path: holds the active animation,
// steps its frame counter at a programmable rate and defers animation changes to the wrap.
module anim_frame_sequencer #(
    parameter int DIV_BASE = 10_000_000,
    parameter int PRESC_W  = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   anim_req,
    input  logic [1:0]   speed,
    input  logic         pause,
    input  logic         step,
    input  logic [4:0]   limit,
    output logic [3:0]   cur_anim,
    output logic [4:0]   frame,
    output logic         frame_tick,
    output logic         wrap,
    output logic         pending
);

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;

    localparam logic [PRESC_W-1:0] BASE = PRESC_W'(DIV_BASE);
    localparam logic [PRESC_W-1:0] ONE  = PRESC_W'(1);

    logic [1:0]         state;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] p_last;
    logic [3:0]         req_lat;
    logic               step_d;
    logic               step_edge;

    logic [4:0]         lim_m1;
    logic               at_end;
    logic               adv_rate;
    logic               advance;
    logic               new_req;
    logic               cancel;
    logic               pending_nxt;
    logic [3:0]         req_nxt;

    assign p_last = (BASE >> speed) - ONE;

    always_comb begin
        lim_m1      = (limit == 5'd0) ? 5'd0 : limit - 5'd1;
        // >= rather than == so a frame left over from a longer animation still wraps
        at_end      = (frame >= lim_m1);
        adv_rate    = (state == S_RUN) && (presc == p_last);
        new_req     = (anim_req != cur_anim) && (!pending || (anim_req != req_lat));
        cancel      = pending && (anim_req == cur_anim);
        pending_nxt = new_req || (pending && !cancel);
        req_nxt     = new_req ? anim_req : req_lat;
        advance     = 1'b0;
        case (state)
            S_RUN:   advance = adv_rate;
            S_HOLD:  advance = step_edge && !pending_nxt;
            default: advance = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_RUN;
            presc      <= '0;
            req_lat    <= 4'd0;
            step_d     <= 1'b0;
            step_edge  <= 1'b0;
            cur_anim   <= 4'd0;
            frame      <= 5'd0;
            frame_tick <= 1'b0;
            wrap       <= 1'b0;
            pending    <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            wrap       <= 1'b0;
            step_d     <= step;
            step_edge  <= step && !step_d;

            if (state != S_LOAD) begin
                pending <= pending_nxt;
                req_lat <= req_nxt;
            end

            if (advance) begin
                frame_tick <= 1'b1;
                if (at_end) begin
                    frame <= 5'd0;
                    wrap  <= 1'b1;
                end else begin
                    frame <= frame + 5'd1;
                end
            end

            case (state)
                S_RUN: begin
                    if (advance && at_end && pending_nxt) begin
                        state <= S_LOAD;
                        presc <= '0;
                    end else if (pause) begin
                        state <= S_HOLD;
                        presc <= '0;
                    end else if (presc >= p_last) begin
                        // also catches a count stranded above a freshly shortened period
                        presc <= '0;
                    end else begin
                        presc <= presc + ONE;
                    end
                end
                S_HOLD: begin
                    presc <= '0;
                    if (pending_nxt) begin
                        state <= S_LOAD;
                    end else if (!pause) begin
                        state <= S_RUN;
                    end
                end
                S_LOAD: begin
                    cur_anim <= req_lat;
                    frame    <= 5'd0;
                    presc    <= '0;
                    pending  <= 1'b0;
                    state    <= pause ? S_HOLD : S_RUN;
                end
                default: begin
                    state <= S_RUN;
                    presc <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Directed bench for anim_frame_sequencer with DIV_BASE=8.
module tb_anim_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] anim_req;
    logic [1:0] speed;
    logic       pause;
    logic       step;
    logic [4:0] limit;
    logic [3:0] cur_anim;
    logic [4:0] frame;
    logic       frame_tick;
    logic       wrap;
    logic       pending;

    int errors = 0;
    int checks = 0;

    anim_frame_sequencer #(.DIV_BASE(8), .PRESC_W(4)) dut (
        .clk(clk), .rst(rst), .anim_req(anim_req), .speed(speed), .pause(pause),
        .step(step), .limit(limit), .cur_anim(cur_anim), .frame(frame),
        .frame_tick(frame_tick), .wrap(wrap), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of clock edges until frame_tick is seen (capped at 200).
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            clk1();
            n++;
        end while (!frame_tick && n < 200);
    endtask

    task automatic do_reset(input logic [1:0] spd, input logic [4:0] lim);
        rst = 1'b1; anim_req = 4'd0; speed = spd; pause = 1'b0; step = 1'b0; limit = lim;
        clk1();
        clk1();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; anim_req = 4'd9; speed = 2'd0; pause = 1'b0; step = 1'b0; limit = 5'd10;
        clk1();
        clk1();
        checks += 5;
        if (cur_anim !== 4'd0) begin errors++; $display("FAIL reset_cur_anim got=%0d exp=0", cur_anim); end
        if (frame !== 5'd0) begin errors++; $display("FAIL reset_frame got=%0d exp=0", frame); end
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
        if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0", pending); end
    endtask

    task automatic test_period();
        int n;
        do_reset(2'd0, 5'd10);
        for (int i = 1; i <= 10; i++) begin
            wait_tick(n);
            checks += 3;
            if (n !== 8) begin errors++; $display("FAIL period_gap i=%0d got=%0d exp=8", i, n); end
            if (frame !== 5'(i % 10)) begin errors++; $display("FAIL period_frame i=%0d got=%0d exp=%0d", i, frame, i % 10); end
            if (wrap !== (i == 10)) begin errors++; $display("FAIL period_wrap i=%0d got=%b exp=%b", i, wrap, i == 10); end
        end
    endtask

    task automatic test_fast();
        do_reset(2'd3, 5'd2);
        for (int k = 1; k <= 6; k++) begin
            clk1();
            checks += 3;
            if (frame !== 5'(k % 2)) begin errors++; $display("FAIL fast_frame k=%0d got=%0d exp=%0d", k, frame, k % 2); end
            if (frame_tick !== 1'b1) begin errors++; $display("FAIL fast_tick k=%0d got=%b exp=1", k, frame_tick); end
            if (wrap !== (k % 2 == 0)) begin errors++; $display("FAIL fast_wrap k=%0d got=%b exp=%b", k, wrap, k % 2 == 0); end
        end
    endtask

    task automatic test_anim_switch();
        int n;
        do_reset(2'd0, 5'd6);
        for (int i = 0; i < 3; i++) wait_tick(n);
        checks++;
        if (frame !== 5'd3) begin errors++; $display("FAIL sw_start_frame got=%0d exp=3", frame); end
        anim_req = 4'd7;
        clk1();
        checks += 2;
        if (pending !== 1'b1) begin errors++; $display("FAIL sw_pending got=%b exp=1", pending); end
        if (cur_anim !== 4'd0) begin errors++; $display("FAIL sw_cur_early got=%0d exp=0", cur_anim); end
        for (int i = 0; i < 3; i++) wait_tick(n);
        checks += 3;
        if (wrap !== 1'b1) begin errors++; $display("FAIL sw_wrap got=%b exp=1", wrap); end
        if (cur_anim !== 4'd0) begin errors++; $display("FAIL sw_cur_at_wrap got=%0d exp=0", cur_anim); end
        if (pending !== 1'b1) begin errors++; $display("FAIL sw_pending_at_wrap got=%b exp=1", pending); end
        clk1();
        checks += 3;
        if (cur_anim !== 4'd7) begin errors++; $display("FAIL sw_cur_loaded got=%0d exp=7", cur_anim); end
        if (frame !== 5'd0) begin errors++; $display("FAIL sw_frame_loaded got=%0d exp=0", frame); end
        if (pending !== 1'b0) begin errors++; $display("FAIL sw_pending_clr got=%b exp=0", pending); end
        wait_tick(n);
        checks += 2;
        if (n !== 8) begin errors++; $display("FAIL sw_first_adv_gap got=%0d exp=8", n); end
        if (frame !== 5'd1) begin errors++; $display("FAIL sw_first_adv_frame got=%0d exp=1", frame); end
    endtask

    task automatic test_pause_step();
        int n;
        int ticks;
        do_reset(2'd0, 5'd10);
        for (int i = 0; i < 4; i++) wait_tick(n);
        pause = 1'b1;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            clk1();
            if (frame_tick) ticks++;
        end
        checks += 2;
        if (ticks !== 0) begin errors++; $display("FAIL hold_ticks got=%0d exp=0", ticks); end
        if (frame !== 5'd4) begin errors++; $display("FAIL hold_frame got=%0d exp=4", frame); end
        for (int s = 0; s < 3; s++) begin
            step = 1'b1;
            clk1();
            step = 1'b0;
            clk1();
            clk1();
            clk1();
            checks++;
            if (frame !== 5'(5 + s)) begin errors++; $display("FAIL step_frame s=%0d got=%0d exp=%0d", s, frame, 5 + s); end
        end
        pause = 1'b0;
        wait_tick(n);
        checks += 2;
        // one cycle to leave HOLD, then a full 8-cycle period from a cleared prescaler
        if (n !== 9) begin errors++; $display("FAIL resume_gap got=%0d exp=9", n); end
        if (frame !== 5'd8) begin errors++; $display("FAIL resume_frame got=%0d exp=8", frame); end
    endtask

    task automatic test_cancel_and_limit0();
        int n;
        do_reset(2'd1, 5'd6);
        anim_req = 4'd7;
        clk1();
        checks++;
        if (pending !== 1'b1) begin errors++; $display("FAIL cancel_set got=%b exp=1", pending); end
        anim_req = 4'd0;
        clk1();
        checks++;
        if (pending !== 1'b0) begin errors++; $display("FAIL cancel_clr got=%b exp=0", pending); end
        for (int i = 0; i < 6; i++) wait_tick(n);
        checks += 2;
        if (wrap !== 1'b1) begin errors++; $display("FAIL cancel_wrap got=%b exp=1", wrap); end
        if (frame !== 5'd0) begin errors++; $display("FAIL cancel_wrap_frame got=%0d exp=0", frame); end
        clk1();
        wait_tick(n);
        checks += 3;
        if (n !== 3) begin errors++; $display("FAIL cancel_no_load_gap got=%0d exp=3", n); end
        if (frame !== 5'd1) begin errors++; $display("FAIL cancel_next_frame got=%0d exp=1", frame); end
        if (cur_anim !== 4'd0) begin errors++; $display("FAIL cancel_cur got=%0d exp=0", cur_anim); end
        limit = 5'd0;
        for (int i = 0; i < 3; i++) begin
            wait_tick(n);
            checks += 3;
            if (n !== 4) begin errors++; $display("FAIL lim0_gap i=%0d got=%0d exp=4", i, n); end
            if (frame !== 5'd0) begin errors++; $display("FAIL lim0_frame i=%0d got=%0d exp=0", i, frame); end
            if (wrap !== 1'b1) begin errors++; $display("FAIL lim0_wrap i=%0d got=%b exp=1", i, wrap); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset(2'd0, 5'd10);
        wait_tick(n);
        wait_tick(n);
        anim_req = 4'd5;
        clk1();
        checks++;
        if (pending !== 1'b1) begin errors++; $display("FAIL mid_pending got=%b exp=1", pending); end
        rst = 1'b1;
        anim_req = 4'd0;
        clk1();
        rst = 1'b0;
        checks += 5;
        if (cur_anim !== 4'd0) begin errors++; $display("FAIL mid_cur got=%0d exp=0", cur_anim); end
        if (frame !== 5'd0) begin errors++; $display("FAIL mid_frame got=%0d exp=0", frame); end
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL mid_tick got=%b exp=0", frame_tick); end
        if (wrap !== 1'b0) begin errors++; $display("FAIL mid_wrap got=%b exp=0", wrap); end
        if (pending !== 1'b0) begin errors++; $display("FAIL mid_pending_clr got=%b exp=0", pending); end
        wait_tick(n);
        checks += 2;
        if (n !== 8) begin errors++; $display("FAIL mid_restart_gap got=%0d exp=8", n); end
        if (frame !== 5'd1) begin errors++; $display("FAIL mid_restart_frame got=%0d exp=1", frame); end
    endtask

    task automatic test_back_to_back();
        do_reset(2'd3, 5'd2);
        clk1();
        anim_req = 4'd3;
        clk1();
        checks += 4;
        if (wrap !== 1'b1) begin errors++; $display("FAIL b2b_wrap got=%b exp=1", wrap); end
        if (frame !== 5'd0) begin errors++; $display("FAIL b2b_frame got=%0d exp=0", frame); end
        if (pending !== 1'b1) begin errors++; $display("FAIL b2b_pending got=%b exp=1", pending); end
        if (cur_anim !== 4'd0) begin errors++; $display("FAIL b2b_cur_old got=%0d exp=0", cur_anim); end
        clk1();
        checks += 3;
        if (cur_anim !== 4'd3) begin errors++; $display("FAIL b2b_cur_new got=%0d exp=3", cur_anim); end
        if (pending !== 1'b0) begin errors++; $display("FAIL b2b_pending_clr got=%b exp=0", pending); end
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL b2b_load_tick got=%b exp=0", frame_tick); end
        clk1();
        checks += 2;
        if (frame !== 5'd1) begin errors++; $display("FAIL b2b_after_frame got=%0d exp=1", frame); end
        if (frame_tick !== 1'b1) begin errors++; $display("FAIL b2b_after_tick got=%b exp=1", frame_tick); end
    endtask

    initial begin
        test_reset();
        test_period();
        test_fast();
        test_anim_switch();
        test_pause_step();
        test_cancel_and_limit0();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
